// File: rtl/abs_diff_err_eval.sv
// Exhaustive error evaluator for W-bit approximate absolute-difference units.
// Sweeps every (a,b) pair through the DUT and accumulates error count, max ED and sum of ED.

module abs_diff_err_metric #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] res,
    output logic [W-1:0] ed,
    output logic         err
);
    logic [W-1:0] exact;
    logic [W:0]   diff;
    logic [W:0]   mag;

    always_comb begin
        exact = (a > b) ? (a - b) : (b - a);
        diff  = {1'b0, res} - {1'b0, exact};
        // Difference of two W-bit values always fits in W bits once made positive.
        mag   = diff[W] ? (~diff + 1'b1) : diff;
        ed    = mag[W-1:0];
        err   = (res != exact);
    end
endmodule

module abs_diff_err_eval #(
    parameter int W       = 2,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           drv_valid,
    output logic [W-1:0]   drv_a,
    output logic [W-1:0]   drv_b,
    input  logic           res_valid,
    input  logic [W-1:0]   res,
    output logic           busy,
    output logic           done,
    output logic           timeout,
    output logic [2*W:0]   err_count,
    output logic [W-1:0]   max_ed,
    output logic [3*W:0]   sum_ed
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ACC   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]     state;
    logic [2*W-1:0] idx;
    logic [TW-1:0]  wcnt;
    logic [W-1:0]   res_q;
    logic [W-1:0]   ed;
    logic           err;

    assign drv_a     = idx[W-1:0];
    assign drv_b     = idx[2*W-1:W];
    assign drv_valid = (state == S_ISSUE) || (state == S_WAIT);
    assign busy      = (state == S_ISSUE) || (state == S_WAIT) || (state == S_ACC);
    assign done      = (state == S_DONE);

    abs_diff_err_metric #(.W(W)) u_metric (
        .a   (drv_a),
        .b   (drv_b),
        .res (res_q),
        .ed  (ed),
        .err (err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            wcnt      <= '0;
            res_q     <= '0;
            timeout   <= 1'b0;
            err_count <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_ISSUE;
                        idx       <= '0;
                        wcnt      <= '0;
                        timeout   <= 1'b0;
                        err_count <= '0;
                        max_ed    <= '0;
                        sum_ed    <= '0;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (res_valid) begin
                        res_q <= res;
                        state <= S_ACC;
                    end else if (wcnt == TW'(TIMEOUT - 1)) begin
                        timeout <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_ACC: begin
                    if (err)
                        err_count <= err_count + (2*W+1)'(1);
                    if (ed > max_ed)
                        max_ed <= ed;
                    sum_ed <= sum_ed + (3*W+1)'(ed);
                    if (idx == '1) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        wcnt  <= '0;
                        state <= S_ISSUE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
